nonce_scheduler: RTL and testbench
==================================

Name: nonce_scheduler

Overview:
- Mining controller that sequences one sha256d_wrapper instance over a range of nonces.
- Holds the 19 fixed 32-bit block-header words and inserts the current nonce as word 19.
- Serves the core's word-request handshake, checks each digest against a leading-zero difficulty, and stops on the first hit or when the range is exhausted.
- Sits between the host/config path and the hash core.

Parameters:
- NONCE_W, 32, nonce width in bits; must be 32 to match header word 19.
- HDR_WORDS, 19, number of stored header words (addr 0..HDR_WORDS-1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- hdr_we  in  1  header write strobe; honoured only in IDLE
- hdr_addr  in  5  header word index; writes with addr>=19 are ignored
- hdr_wdata  in  32  header word data
- nonce_base  in  32  first nonce; sampled on go
- nonce_end  in  32  last nonce, inclusive; sampled on go
- tgt_zeros  in  9  required leading zero bits of the hash, 0..256; sampled on go
- go  in  1  start search; honoured only in IDLE
- abort  in  1  stop search
- busy  out  1  high from the go-accept cycle until return to IDLE
- found  out  1  level; set on a hit, cleared on the next accepted go
- exhausted  out  1  level; set when the range ends with no hit, cleared on the next accepted go
- found_nonce  out  32  nonce of the hit; valid while found=1
- cur_nonce  out  32  nonce currently being hashed
- core_start  out  1  one-cycle start pulse to the core
- core_addr  in  5  word index requested by the core
- core_rq  in  1  core data request
- core_data  out  32  word returned to the core
- core_rdy  out  1  one-cycle data-valid pulse to the core
- core_hash  in  256  core digest, MSB = hash[255]; valid while core_done=1
- core_done  in  1  core completion

Behaviour:
- Reset values: every output is 0, state is IDLE, header RAM is not cleared.
- States: IDLE, START, FEED, CHECK, DRAIN.
- IDLE -> START on go: latch base/end/tgt_zeros, set cur_nonce=nonce_base, clear found/exhausted, set busy=1.
- START: drive core_start=1 for exactly one cycle, then go to FEED.
- FEED, request handshake:
  - If core_rq=1 and core_rdy=0, then on the next cycle core_rdy=1 and core_data is driven from core_addr.
  - core_data mapping: addr 0..18 -> header word, addr 19 -> cur_nonce, addr 20..31 -> 32'h0.
  - core_rdy is always a single-cycle pulse. core_rq is ignored during the core_rdy cycle.
  - Latency from request to data is 1 cycle.
- FEED, completion: when core_done=1, register match = (tgt_zeros<=256) and (core_hash[255 -: tgt_zeros] all zero). tgt_zeros=0 always matches. Then go to CHECK.
- CHECK (1 cycle):
  - match: found=1, found_nonce=cur_nonce, go to IDLE.
  - no match and cur_nonce==nonce_end: exhausted=1, go to IDLE.
  - otherwise: cur_nonce+1 (mod 2^32), go to START.
- Range wrap: nonce_end<nonce_base is legal; the search wraps through 0xFFFFFFFF -> 0. nonce_base==nonce_end gives exactly one attempt.
- abort:
  - In START, FEED or CHECK: go to DRAIN. The core cannot be cancelled, so DRAIN keeps serving requests and waits for core_done.
  - If abort arrives in START, core_start has already been issued and DRAIN waits for that run to finish.
  - DRAIN -> IDLE. Neither found nor exhausted is set. An in-flight hit is discarded.
  - abort in CHECK takes priority over a match.
- go while busy is ignored. hdr_we while busy is ignored.
- busy=0 only in IDLE.
- rst has priority over every input, including mid-handshake.

Optional Feature:
- Macro: NONCE_SCHED_STATS_EN.
- Defined: adds output attempts[31:0], cleared on an accepted go and incremented in each CHECK cycle, saturating at 0xFFFFFFFF. Also adds output cycles[31:0], counting busy cycles and saturating.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Bench uses a stub core: 20 requests for addr 0..19, done 4 cycles after the last rdy, hash = {nonce word, 224'hFF..FF}.
- Header write addr 0..18 = 32'h0000_0000+addr; go with base=5, end=5, tgt=29 -> word k returns k for k=0..18 and nonce 5 for k=19; core_rdy exactly one pulse per request; hash MSBs 00000005 give 29 leading zeros -> found=1, found_nonce=5.
- base=0x10, end=0x13, tgt=31 -> nonces 0x10..0x13 attempted, each with 27 leading zeros; no hit -> exhausted=1 after 4 START pulses; found=0.
- base=0xFFFF_FFFE, end=0x0000_0001, tgt=32 -> attempts FFFFFFFE, FFFFFFFF, 00000000 -> hit at 0x00000000; 3 core_start pulses total.
- tgt=0 with any base -> found on the first attempt. tgt=300 -> never found; exhausted after the range.
- abort during FEED at word 7 -> core is still served to done, busy drops only after core_done, found=exhausted=0; a following go is accepted.
- hdr_we and go pulsed while busy -> header RAM unchanged (read back on the next run), no restart. rst mid-FEED -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/nonce_scheduler.sv
// Nonce search controller driving one sha256d core: serves header words, checks digests for leading zeros.
// Optional NONCE_SCHED_STATS_EN adds saturating attempt and busy-cycle counters.
module nonce_scheduler #(
  parameter int NONCE_W   = 32,
  parameter int HDR_WORDS = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hdr_we,
  input  logic [4:0]         hdr_addr,
  input  logic [31:0]        hdr_wdata,
  input  logic [NONCE_W-1:0] nonce_base,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic [8:0]         tgt_zeros,
  input  logic               go,
  input  logic               abort,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [NONCE_W-1:0] cur_nonce,
  output logic               core_start,
  input  logic [4:0]         core_addr,
  input  logic               core_rq,
  output logic [31:0]        core_data,
  output logic               core_rdy,
  input  logic [255:0]       core_hash,
  input  logic               core_done
`ifdef NONCE_SCHED_STATS_EN
  ,
  output logic [31:0]        attempts,
  output logic [31:0]        cycles
`endif
);

  typedef enum logic [2:0] {IDLE, START, FEED, CHECK, DRAIN} state_t;

  localparam logic [4:0] HDR_LIMIT = 5'(HDR_WORDS);

  state_t             state;
  logic [31:0]        hdr_mem [HDR_WORDS];
  logic [NONCE_W-1:0] end_r;
  logic [8:0]         tgt_r;
  logic               match_r;
  logic               core_active;
  logic               hash_ok;
  logic [31:0]        rd_word;

  // Shifting right by (256 - tgt) leaves exactly the top tgt bits; tgt=0 shifts everything out.
  always_comb begin
    hash_ok = (tgt_r <= 9'd256) && ((core_hash >> (9'd256 - tgt_r)) == 256'd0);
  end

  always_comb begin
    rd_word = 32'h0;
    if (core_addr < HDR_LIMIT)
      rd_word = hdr_mem[core_addr];
    else if (core_addr == HDR_LIMIT)
      rd_word = cur_nonce;
  end

  // Header RAM has no reset; it keeps its contents across runs and resets.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && hdr_we && hdr_addr < HDR_LIMIT)
      hdr_mem[hdr_addr] <= hdr_wdata;
  end

  // core_active tracks an issued core run that has not yet reported done, so DRAIN never waits forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      found_nonce <= '0;
      cur_nonce   <= '0;
      core_start  <= 1'b0;
      core_data   <= 32'h0;
      core_rdy    <= 1'b0;
      end_r       <= '0;
      tgt_r       <= 9'd0;
      match_r     <= 1'b0;
      core_active <= 1'b0;
    end else begin
      core_start <= 1'b0;
      if (state inside {START, FEED, DRAIN} && core_rq && !core_rdy) begin
        core_rdy  <= 1'b1;
        core_data <= rd_word;
      end else begin
        core_rdy <= 1'b0;
      end
      if (core_done)
        core_active <= 1'b0;

      case (state)
        IDLE: begin
          if (go) begin
            end_r       <= nonce_end;
            tgt_r       <= tgt_zeros;
            cur_nonce   <= nonce_base;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            busy        <= 1'b1;
            core_start  <= 1'b1;
            core_active <= 1'b1;
            state       <= START;
          end
        end
        START: state <= abort ? DRAIN : FEED;
        FEED: begin
          if (abort) begin
            state <= DRAIN;
          end else if (core_done) begin
            match_r <= hash_ok;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (abort) begin
            state <= DRAIN;
          end else if (match_r) begin
            found       <= 1'b1;
            found_nonce <= cur_nonce;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (cur_nonce == end_r) begin
            exhausted <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cur_nonce   <= cur_nonce + 1'b1;
            core_start  <= 1'b1;
            core_active <= 1'b1;
            state       <= START;
          end
        end
        DRAIN: begin
          if (core_done || !core_active) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NONCE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      attempts <= 32'h0;
      cycles   <= 32'h0;
    end else if (state == IDLE && go) begin
      attempts <= 32'h0;
      cycles   <= 32'h0;
    end else begin
      if (state == CHECK && attempts != 32'hFFFF_FFFF)
        attempts <= attempts + 32'h1;
      if (busy && cycles != 32'hFFFF_FFFF)
        cycles <= cycles + 32'h1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_nonce_scheduler.sv
// Scoreboard bench for nonce_scheduler: stub core plus a reference model of the nonce search.
module tb_nonce_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         hdr_we;
  logic [4:0]   hdr_addr;
  logic [31:0]  hdr_wdata;
  logic [31:0]  nonce_base;
  logic [31:0]  nonce_end;
  logic [8:0]   tgt_zeros;
  logic         go;
  logic         abort;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic [31:0]  found_nonce;
  logic [31:0]  cur_nonce;
  logic         core_start;
  logic [4:0]   core_addr;
  logic         core_rq;
  logic [31:0]  core_data;
  logic         core_rdy;
  logic [255:0] core_hash;
  logic         core_done;

  nonce_scheduler dut (
    .clk(clk), .rst(rst), .hdr_we(hdr_we), .hdr_addr(hdr_addr), .hdr_wdata(hdr_wdata),
    .nonce_base(nonce_base), .nonce_end(nonce_end), .tgt_zeros(tgt_zeros), .go(go),
    .abort(abort), .busy(busy), .found(found), .exhausted(exhausted),
    .found_nonce(found_nonce), .cur_nonce(cur_nonce), .core_start(core_start),
    .core_addr(core_addr), .core_rq(core_rq), .core_data(core_data), .core_rdy(core_rdy),
    .core_hash(core_hash), .core_done(core_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fnd;
    logic        exh;
    logic [31:0] fnonce;
    int          starts;
  } result_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] hdr_model [19];
  logic [31:0] exp_words [$];
  result_t     exp_results [$];
  int          stub_word;
  int          done_cnt;
  int          skip_req = 0;
  int          skip_done = 0;
  int          start_cnt = 0;
  logic        prev_busy = 1'b0;
  logic        prev_rdy = 1'b0;
  result_t     mon_r;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  function automatic int leadZeros(input logic [31:0] n);
    int z = 0;
    for (int i = 31; i >= 0; i--) begin
      if (n[i]) return z;
      z++;
    end
    return z;
  endfunction

  // Reference search: stub digest is {nonce, all ones}, so its leading zeros are those of the nonce word.
  task automatic modelRun(input logic [31:0] base, input logic [31:0] last, input int tgt);
    result_t     r;
    logic [31:0] n = base;
    r.fnd = 1'b0; r.exh = 1'b0; r.fnonce = 32'h0; r.starts = 0;
    forever begin
      for (int k = 0; k < 19; k++) exp_words.push_back(hdr_model[k]);
      exp_words.push_back(n);
      r.starts++;
      if (tgt <= 256 && leadZeros(n) >= tgt) begin
        r.fnd = 1'b1; r.fnonce = n;
        break;
      end
      if (n == last) begin
        r.exh = 1'b1;
        break;
      end
      n = n + 32'h1;
    end
    exp_results.push_back(r);
  endtask

  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] last, input int tgt);
    @(negedge clk);
    nonce_base = base; nonce_end = last; tgt_zeros = 9'(tgt); go = 1'b1;
    modelRun(base, last, tgt);
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic writeHdr(input int addr, input logic [31:0] data);
    @(negedge clk);
    hdr_we = 1'b1; hdr_addr = 5'(addr); hdr_wdata = data;
    @(negedge clk);
    hdr_we = 1'b0;
    if (addr < 19) hdr_model[addr] = data;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("[TB] FAIL idle_timeout: actual=busy required=idle");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic waitStubWord(input int w);
    int n = 0;
    while (!(busy && stub_word == w) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("[TB] FAIL stub_word_timeout: actual=%0d required=%0d", stub_word, w);
    end
  endtask

  // Stub core: requests words 0..19, then reports done 4 cycles after the last data.
  task automatic serveRun();
    logic [31:0] nw = 32'h0;
    bit          ok;
    for (int k = 0; k < 20; k++) begin
      core_rq = 1'b1; core_addr = 5'(k); stub_word = k; ok = 1'b0;
      for (int w = 0; w < 10 && !ok; w++) begin
        @(negedge clk);
        if (rst) begin
          core_rq = 1'b0;
          return;
        end
        if (core_rdy) ok = 1'b1;
      end
      if (!ok) begin
        core_rq = 1'b0;
        total++; bad++;
        $display("[TB] FAIL rdy_timeout: actual=no_rdy required=rdy word=%0d", k);
        return;
      end
      if (k == 19) nw = core_data;
    end
    core_rq = 1'b0;
    repeat (4) @(negedge clk);
    core_hash = {nw, {224{1'b1}}};
    core_done = 1'b1;
    done_cnt++;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  initial begin
    core_rq = 1'b0; core_addr = 5'd0; core_done = 1'b0; core_hash = '0;
    stub_word = 0; done_cnt = 0;
    forever begin
      @(negedge clk);
      if (core_start && !rst) serveRun();
    end
  end

  // Monitor: pops expected words on each data pulse and expected run results when busy falls.
  always @(negedge clk) begin
    if (core_start) start_cnt++;
    if (core_rdy) begin
      checkOutput("rdy_single_pulse", {127'd0, prev_rdy}, 128'd0);
      if (exp_words.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_word: actual=%0h required=none", core_data);
      end else begin
        checkOutput("core_data", {96'd0, core_data}, {96'd0, exp_words.pop_front()});
      end
    end
    if (prev_busy && !busy) begin
      if (skip_done < skip_req) begin
        skip_done++;
      end else if (exp_results.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_end: actual=run_end required=none");
      end else begin
        mon_r = exp_results.pop_front();
        checkOutput("found", {127'd0, found}, {127'd0, mon_r.fnd});
        checkOutput("exhausted", {127'd0, exhausted}, {127'd0, mon_r.exh});
        checkOutput("start_pulses", 128'(start_cnt), 128'(mon_r.starts));
        if (mon_r.fnd) checkOutput("found_nonce", {96'd0, found_nonce}, {96'd0, mon_r.fnonce});
      end
      start_cnt = 0;
    end
    prev_busy = busy;
    prev_rdy  = core_rdy;
  end

  initial begin
    int d0;
    logic [31:0] b;
    rst = 1'b1; hdr_we = 1'b0; hdr_addr = 5'd0; hdr_wdata = 32'h0;
    nonce_base = 32'h0; nonce_end = 32'h0; tgt_zeros = 9'd0; go = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_flags", {124'd0, busy, found, exhausted, core_start}, 128'd0);
    checkOutput("reset_data", {31'd0, core_rdy, found_nonce, cur_nonce, core_data}, 128'd0);
    rst = 1'b0;
    for (int k = 0; k < 19; k++) writeHdr(k, 32'(k));

    $display("[TB] single nonce hit");
    applyStimulus(32'd5, 32'd5, 29);
    waitIdle(2000);

    $display("[TB] range exhausted, with hdr_we and go while busy");
    applyStimulus(32'h10, 32'h13, 31);
    waitStubWord(3);
    hdr_we = 1'b1; hdr_addr = 5'd3; hdr_wdata = 32'hDEAD_BEEF; go = 1'b1; nonce_base = 32'h99;
    @(negedge clk);
    hdr_we = 1'b0; go = 1'b0;
    waitIdle(2000);

    $display("[TB] wrap through zero");
    applyStimulus(32'hFFFF_FFFE, 32'h0000_0001, 32);
    waitIdle(2000);

    $display("[TB] target extremes");
    applyStimulus(32'hFFFF_0000, 32'hFFFF_0002, 0);
    waitIdle(2000);
    applyStimulus(32'h0000_0000, 32'h0000_0002, 300);
    waitIdle(2000);

    $display("[TB] abort mid-feed");
    applyStimulus(32'h40, 32'h48, 31);
    waitStubWord(7);
    d0 = done_cnt;
    exp_results[exp_results.size()-1] = '{fnd: 1'b0, exh: 1'b0, fnonce: 32'h0, starts: 1};
    while (exp_words.size() > 20) void'(exp_words.pop_back());
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy_held", {127'd0, busy}, 128'd1);
    waitIdle(2000);
    checkOutput("abort_core_drained", 128'(done_cnt - d0), 128'd1);

    $display("[TB] reset mid-feed");
    applyStimulus(32'h7, 32'h9, 31);
    waitStubWord(5);
    skip_req++;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_flags", {124'd0, busy, found, exhausted, core_start}, 128'd0);
    checkOutput("midrst_data", {31'd0, core_rdy, found_nonce, cur_nonce, core_data}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_words.delete();
    exp_results.delete();
    repeat (2) @(negedge clk);

    $display("[TB] randomized runs");
    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 0) writeHdr($urandom_range(0, 18), $urandom);
      b = (i % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      applyStimulus(b, b + 32'($urandom_range(0, 3)), $urandom_range(0, 34));
      waitIdle(2000);
    end

    repeat (4) @(negedge clk);
    checkOutput("words_consumed", 128'(exp_words.size()), 128'd0);
    checkOutput("results_consumed", 128'(exp_results.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
